// File: rtl/coo_aggregation_ctrl_if.sv
// Bus between the COO aggregation sequencer and its memories:
// COO/product-memory read ports plus the accumulate-write port.
interface coo_aggregation_ctrl_if #(
    parameter int FEATURE_WIDTH  = 3,
    parameter int EDGE_WIDTH     = 3,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16
);
    logic                                        start;
    logic [EDGE_WIDTH-1:0]                       coo_address;
    logic [1:0][FEATURE_WIDTH-1:0]               coo_in;
    logic [FEATURE_WIDTH-1:0]                    fm_wm_read_row;
    logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  fm_wm_row_in;
    logic                                        wr_en;
    logic [FEATURE_WIDTH-1:0]                    write_row;
    logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0]  fm_wm_adj_row_out;
    logic                                        busy;
    logic                                        done;
    logic                                        coo_err;

    modport master (
        input  start, coo_in, fm_wm_row_in,
        output coo_address, fm_wm_read_row, wr_en, write_row,
               fm_wm_adj_row_out, busy, done, coo_err
    );

    modport slave (
        output start, coo_in, fm_wm_row_in,
        input  coo_address, fm_wm_read_row, wr_en, write_row,
               fm_wm_adj_row_out, busy, done, coo_err
    );
endinterface

// File: rtl/coo_aggregation_ctrl.sv
// Sequencer computing (A[+I])*(FM*WM): walks self-loops then COO edges and
// issues one accumulate-write per contribution to the accumulator memory.
module coo_aggregation_ctrl #(
    parameter int FEATURE_ROWS   = 6,
    parameter int WEIGHT_COLS    = 3,
    parameter int DOT_PROD_WIDTH = 16,
    parameter int NUM_EDGES      = 6,
    parameter int ADD_SELF_LOOPS = 1,
    parameter int FEATURE_WIDTH  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
    parameter int EDGE_WIDTH     = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    coo_aggregation_ctrl_if.master agg_if
);
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_SELF_RD    = 4'd1;
    localparam logic [3:0] S_SELF_WR    = 4'd2;
    localparam logic [3:0] S_EDGE_FETCH = 4'd3;
    localparam logic [3:0] S_RD_SRC     = 4'd4;
    localparam logic [3:0] S_WR_DST     = 4'd5;
    localparam logic [3:0] S_RD_DST     = 4'd6;
    localparam logic [3:0] S_WR_SRC     = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    localparam logic [FEATURE_WIDTH:0]   ROWS_X    = (FEATURE_WIDTH+1)'(FEATURE_ROWS);
    localparam logic [FEATURE_WIDTH-1:0] LAST_ROW  = FEATURE_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [EDGE_WIDTH-1:0]    LAST_EDGE = EDGE_WIDTH'(NUM_EDGES - 1);

    typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] row_t;

    logic [3:0]               state_q, state_d;
    logic [EDGE_WIDTH-1:0]    edge_q, edge_d;
    logic [FEATURE_WIDTH-1:0] rd_row_q, rd_row_d;
    logic [FEATURE_WIDTH-1:0] wr_row_q, wr_row_d;
    logic [FEATURE_WIDTH-1:0] src_q, src_d;
    logic [FEATURE_WIDTH-1:0] dst_q, dst_d;
    logic                     bad_q, bad_d;
    logic                     same_q, same_d;
    logic                     coo_err_q, coo_err_d;
    row_t                     data_q, data_d;

    logic [FEATURE_WIDTH-1:0] src_in, dst_in;
    logic                     idx_bad;

    assign src_in  = agg_if.coo_in[0];
    assign dst_in  = agg_if.coo_in[1];
    assign idx_bad = ({1'b0, src_in} >= ROWS_X) || ({1'b0, dst_in} >= ROWS_X);

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        rd_row_d  = rd_row_q;
        wr_row_d  = wr_row_q;
        src_d     = src_q;
        dst_d     = dst_q;
        bad_d     = bad_q;
        same_d    = same_q;
        coo_err_d = coo_err_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE: begin
                if (agg_if.start) begin
                    coo_err_d = 1'b0;
                    edge_d    = '0;
                    rd_row_d  = '0;
                    state_d   = (ADD_SELF_LOOPS != 0) ? S_SELF_RD : S_EDGE_FETCH;
                end
            end
            S_SELF_RD: begin
                data_d   = agg_if.fm_wm_row_in;
                wr_row_d = rd_row_q;
                state_d  = S_SELF_WR;
            end
            S_SELF_WR: begin
                if (rd_row_q == LAST_ROW) begin
                    state_d = S_EDGE_FETCH;
                end else begin
                    rd_row_d = rd_row_q + 1'b1;
                    state_d  = S_SELF_RD;
                end
            end
            S_EDGE_FETCH: begin
                src_d    = src_in;
                dst_d    = dst_in;
                bad_d    = idx_bad;
                same_d   = (src_in == dst_in);
                rd_row_d = src_in;
                if (idx_bad) coo_err_d = 1'b1;
                state_d  = S_RD_SRC;
            end
            // Captures only update on enabled writes so row/data hold between strobes.
            S_RD_SRC: begin
                if (!bad_q) begin
                    data_d   = agg_if.fm_wm_row_in;
                    wr_row_d = dst_q;
                end
                state_d = S_WR_DST;
            end
            S_WR_DST: begin
                rd_row_d = dst_q;
                state_d  = S_RD_DST;
            end
            S_RD_DST: begin
                if (!bad_q && !same_q) begin
                    data_d   = agg_if.fm_wm_row_in;
                    wr_row_d = src_q;
                end
                state_d = S_WR_SRC;
            end
            S_WR_SRC: begin
                if (edge_q == LAST_EDGE) begin
                    state_d = S_DONE;
                end else begin
                    edge_d  = edge_q + 1'b1;
                    state_d = S_EDGE_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            edge_q    <= '0;
            rd_row_q  <= '0;
            wr_row_q  <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            bad_q     <= 1'b0;
            same_q    <= 1'b0;
            coo_err_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            edge_q    <= edge_d;
            rd_row_q  <= rd_row_d;
            wr_row_q  <= wr_row_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            bad_q     <= bad_d;
            same_q    <= same_d;
            coo_err_q <= coo_err_d;
            data_q    <= data_d;
        end
    end

    assign agg_if.coo_address       = edge_q;
    assign agg_if.fm_wm_read_row    = rd_row_q;
    assign agg_if.write_row         = wr_row_q;
    assign agg_if.fm_wm_adj_row_out = data_q;
    assign agg_if.coo_err           = coo_err_q;
    assign agg_if.busy              = (state_q != S_IDLE);
    assign agg_if.done              = (state_q == S_DONE);
    assign agg_if.wr_en             = (state_q == S_SELF_WR)
                                    || ((state_q == S_WR_DST) && !bad_q)
                                    || ((state_q == S_WR_SRC) && !bad_q && !same_q);
endmodule

// File: tb/tb_coo_aggregation_ctrl.sv
// Bench for coo_aggregation_ctrl: directed and randomized passes checked
// against a write-list and adjacency-matrix model of (A+I)*FM.
module tb_coo_aggregation_ctrl;
    localparam int FR = 6;
    localparam int WC = 3;
    localparam int DW = 16;
    localparam int NE = 6;
    localparam int FW = 3;
    localparam int EW = 3;
    localparam int RW = WC * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    coo_aggregation_ctrl_if #(.FEATURE_WIDTH(FW), .EDGE_WIDTH(EW),
        .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW)) bus ();
    coo_aggregation_ctrl_if #(.FEATURE_WIDTH(FW), .EDGE_WIDTH(1),
        .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW)) bus1 ();

    coo_aggregation_ctrl #(.FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW),
        .NUM_EDGES(NE), .ADD_SELF_LOOPS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .agg_if(bus.master));

    coo_aggregation_ctrl #(.FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW),
        .NUM_EDGES(1), .ADD_SELF_LOOPS(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .agg_if(bus1.master));

    logic [RW-1:0] fm   [8];
    logic [FW-1:0] csrc [8];
    logic [FW-1:0] cdst [8];
    logic [FW-1:0] e1_src, e1_dst;

    assign bus.coo_in        = {cdst[bus.coo_address], csrc[bus.coo_address]};
    assign bus.fm_wm_row_in  = fm[bus.fm_wm_read_row];
    assign bus1.coo_in       = {e1_dst, e1_src};
    assign bus1.fm_wm_row_in = fm[bus1.fm_wm_read_row];

    typedef struct packed {
        logic [FW-1:0] row;
        logic [RW-1:0] data;
    } wr_t;

    wr_t  obs_q[$];
    wr_t  exp_q[$];
    logic exp_err;
    int   done_cnt;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) obs_q.push_back('{bus.write_row, bus.fm_wm_adj_row_out});
            if (bus.done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Ordered contributions: every self row, then per valid edge dst<-src and src<-dst.
    task automatic build_model();
        exp_q.delete();
        exp_err = 1'b0;
        for (int r = 0; r < FR; r++) exp_q.push_back('{FW'(r), fm[r]});
        for (int e = 0; e < NE; e++) begin
            if (int'(csrc[e]) >= FR || int'(cdst[e]) >= FR) exp_err = 1'b1;
            else begin
                exp_q.push_back('{cdst[e], fm[csrc[e]]});
                if (csrc[e] != cdst[e]) exp_q.push_back('{csrc[e], fm[cdst[e]]});
            end
        end
    endtask

    task automatic check_acc();
        int cnt [FR][FR];
        logic [DW-1:0] ev, ov;
        for (int k = 0; k < FR; k++)
            for (int j = 0; j < FR; j++) cnt[k][j] = (k == j) ? 1 : 0;
        for (int e = 0; e < NE; e++) begin
            if (int'(csrc[e]) < FR && int'(cdst[e]) < FR) begin
                cnt[cdst[e]][csrc[e]]++;
                if (csrc[e] != cdst[e]) cnt[csrc[e]][cdst[e]]++;
            end
        end
        for (int k = 0; k < FR; k++) begin
            for (int c = 0; c < WC; c++) begin
                ev = '0;
                ov = '0;
                for (int j = 0; j < FR; j++) ev += DW'(cnt[k][j]) * fm[j][c*DW +: DW];
                foreach (obs_q[i]) if (obs_q[i].row == FW'(k)) ov += obs_q[i].data[c*DW +: DW];
                check($sformatf("acc[%0d][%0d]", k, c), 64'(ov), 64'(ev));
            end
        end
    endtask

    task automatic run_pass(input bit pulse);
        int  cyc;
        bit  found;
        obs_q.delete();
        done_cnt = 0;
        build_model();
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'(1));
        check("err_cleared", 64'(bus.coo_err), 64'(0));
        cyc = 0;
        found = 1'b0;
        while (!found && cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.done) found = 1'b1;
            else bus.start = pulse && (cyc == 10 || cyc == 20);
        end
        bus.start = 1'b0;
        check("done_seen", 64'(found), 64'(1));
        check("latency", 64'(cyc), 64'(42));
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(bus.done), 64'(0));
        check("idle_after_done", 64'(bus.busy), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("coo_err", 64'(bus.coo_err), 64'(exp_err));
        check("wr_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("wr%0d_row", i), 64'(obs_q[i].row), 64'(exp_q[i].row));
            check($sformatf("wr%0d_data", i), 64'(obs_q[i].data), 64'(exp_q[i].data));
        end
        check_acc();
    endtask

    task automatic load_ring();
        for (int i = 0; i < 8; i++) begin
            fm[i] = {DW'(3*(i+1)), DW'(2*(i+1)), DW'(i+1)};
            csrc[i] = FW'(i % FR);
            cdst[i] = FW'((i + 1) % FR);
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus1.start = 1'b0;
        e1_src = 3'd0;
        e1_dst = 3'd3;
        done_cnt = 0;
        load_ring();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", 64'(bus.wr_en), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_coo_err", 64'(bus.coo_err), 64'(0));
        check("rst_coo_addr", 64'(bus.coo_address), 64'(0));
        check("rst_rd_row", 64'(bus.fm_wm_read_row), 64'(0));
        check("rst_wr_row", 64'(bus.write_row), 64'(0));
        check("rst_data", 64'(bus.fm_wm_adj_row_out), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        // Ring graph, then self-edge (2,2), out-of-range edge (7,1) and stray starts
        run_pass(1'b0);
        csrc[2] = 3'd2; cdst[2] = 3'd2;
        csrc[3] = 3'd7; cdst[3] = 3'd1;
        run_pass(1'b1);

        // Asynchronous reset in the middle of a write of edge 4
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (34) @(posedge clk);
        #1;
        check("pre_rst_wr_en", 64'(bus.wr_en), 64'(1));
        check("pre_rst_err", 64'(bus.coo_err), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(bus.wr_en), 64'(0));
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_done", 64'(bus.done), 64'(0));
        check("mid_rst_err", 64'(bus.coo_err), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(bus.busy), 64'(0));
        check("post_rst_wr_en", 64'(bus.wr_en), 64'(0));

        // No self loops, single edge (0,3)
        @(negedge clk) bus1.start = 1'b1;
        @(posedge clk);
        #1 bus1.start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("e1_wr_en_c%0d", k), 64'(bus1.wr_en), 64'(k == 2 || k == 4));
            check($sformatf("e1_done_c%0d", k), 64'(bus1.done), 64'(k == 5));
            if (k == 1) check("e1_rd_src", 64'(bus1.fm_wm_read_row), 64'(e1_src));
            if (k == 3) check("e1_rd_dst", 64'(bus1.fm_wm_read_row), 64'(e1_dst));
            if (k == 2 || k == 3) begin
                check($sformatf("e1_row_c%0d", k), 64'(bus1.write_row), 64'(e1_dst));
                check($sformatf("e1_data_c%0d", k), 64'(bus1.fm_wm_adj_row_out), 64'(fm[e1_src]));
            end
            if (k == 4 || k == 5) begin
                check($sformatf("e1_row_c%0d", k), 64'(bus1.write_row), 64'(e1_src));
                check($sformatf("e1_data_c%0d", k), 64'(bus1.fm_wm_adj_row_out), 64'(fm[e1_dst]));
            end
        end

        // Randomized graphs and feature rows
        for (int p = 0; p < 5; p++) begin
            for (int i = 0; i < 8; i++) begin
                fm[i] = RW'({$urandom(), $urandom()});
                csrc[i] = ($urandom_range(0, 9) == 0) ? FW'($urandom_range(6, 7)) : FW'($urandom_range(0, 5));
                cdst[i] = ($urandom_range(0, 9) == 0) ? FW'($urandom_range(6, 7)) : FW'($urandom_range(0, 5));
            end
            if (p == 0) begin
                csrc[1] = 3'd4;
                cdst[1] = 3'd4;
            end
            run_pass(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
